// File: rtl/q8_reg_arbiter_if.sv
// Shared-register arbiter bus: four requesters with packed write-data lanes,
// and the grant/ack/register/busy signals returned by the arbiter.
interface q8_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   nq;
    logic               busy;

    // Requester side drives requests and data, observes the arbiter outputs
    modport master (
        output req, wdata,
        input  gnt, ack, q, nq, busy
    );

    // Arbiter side
    modport slave (
        input  req, wdata,
        output gnt, ack, q, nq, busy
    );
endinterface

// File: rtl/q8_reg_arbiter.sv
// Four-way round-robin arbiter guarding a single shared register.
// A winner is picked in IDLE, owns the bus for one GRANT cycle (during which
// its lane is captured into q) and HOLD further cycles, receives a one-cycle
// ack in the last HOLD cycle, then the bus returns to IDLE for at least one
// cycle with the round-robin pointer moved past the winner.
module q8_reg_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    q8_reg_arbiter_if.slave  bus
);

    // A zero-length hold would leave no cycle in which to issue the ack
    generate
        if (HOLD < 1) begin : g_bad_hold
            $error("q8_reg_arbiter: HOLD must be at least 1");
        end
    endgenerate

    // Counter only needs to hold values 0 .. HOLD-1
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [3:0]       gnt_r;
    logic [3:0]       ack_r;
    logic [WIDTH-1:0] q_r;

    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             found;
    logic [WIDTH-1:0] lanes [4];

    // Unpack the flat write-data bus into per-requester lanes
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign lanes[i] = bus.wdata[i*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first asserted request starting at ptr, wrapping mod 4
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && bus.req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    // Arbitration FSM; all outputs are registered and cleared immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
            ptr   <= '0;
            owner <= '0;
            gnt_r <= '0;
            ack_r <= '0;
            q_r   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_r <= '0;
                    if (bus.req != 4'b0000) begin
                        state <= ST_GRANT;
                        owner <= win_idx;
                        gnt_r <= 4'b0001 << win_idx;
                    end
                end
                ST_GRANT: begin
                    q_r   <= lanes[owner];
                    count <= CW'(HOLD - 1);
                    state <= ST_HOLD;
                    ack_r <= (HOLD == 1) ? gnt_r : 4'b0000;
                end
                ST_HOLD: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                        gnt_r <= '0;
                        ack_r <= '0;
                        ptr   <= owner + 2'd1;
                    end else begin
                        count <= count - CW'(1);
                        ack_r <= (count == CW'(1)) ? gnt_r : 4'b0000;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_r <= '0;
                    ack_r <= '0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.ack  = ack_r;
    assign bus.q    = q_r;
    assign bus.nq   = ~q_r;
    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_q8_reg_arbiter.sv
// Self-checking bench for q8_reg_arbiter. Each scenario task drives requests
// and checks grant/busy/q timing inline; every expected write (owner ack plus
// the value q must hold at ack time) is pushed to a scoreboard when driven
// and popped by a monitor when the DUT pulses ack.
module tb_q8_reg_arbiter;

    localparam int TB_WIDTH = 8;
    localparam int TB_HOLD  = 2;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] data;
    } sb_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    sb_t  sb [$];

    q8_reg_arbiter_if #(.WIDTH(TB_WIDTH)) bus ();

    q8_reg_arbiter #(
        .WIDTH (TB_WIDTH),
        .HOLD  (TB_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard monitor: one-hot checks every cycle, pop and compare on each ack
    always @(negedge clk) begin
        sb_t e;
        total++;
        if ($countones(bus.gnt) > 1 || $countones(bus.ack) > 1) begin
            bad++;
            $display("[TB] FAIL onehot: gnt=%b ack=%b", bus.gnt, bus.ack);
        end
        if (bus.ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected_ack: got ack=%b, none expected", bus.ack);
            end else begin
                e = sb.pop_front();
                total++;
                if (bus.ack !== e.ack) begin
                    bad++;
                    $display("[TB] FAIL sb_ack: got %b expected %b", bus.ack, e.ack);
                end
                total++;
                if (bus.q !== e.data) begin
                    bad++;
                    $display("[TB] FAIL sb_q: got %h expected %h", bus.q, e.data);
                end
            end
        end
    end

    task automatic set_lane(input int i, input logic [7:0] v);
        bus.wdata[i*8 +: 8] = v;
    endtask

    // Reset held 100 ns with clock running; outputs must stay at reset values
    task automatic test_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 10) reset = 1'b1;
            total++;
            if (bus.q !== 8'h00) begin bad++; $display("[TB] FAIL reset_q[%0d]: got %h expected 00", c, bus.q); end
            total++;
            if (bus.nq !== 8'hFF) begin bad++; $display("[TB] FAIL reset_nq[%0d]: got %h expected ff", c, bus.nq); end
            total++;
            if (bus.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt[%0d]: got %b expected 0000", c, bus.gnt); end
            total++;
            if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", c, bus.busy); end
        end
    endtask

    // All four requesting: grants rotate 0,1,2,3,0 with one idle cycle between writes
    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_d [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33); set_lane(3, 8'h44);
        for (int w = 0; w < 5; w++) sb.push_back('{ack: exp_g[w], data: exp_d[w]});
        bus.req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            total++;
            if (bus.gnt !== exp_g[w] || bus.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rr_gnt[%0d]: got gnt=%b busy=%b expected gnt=%b busy=1", w, bus.gnt, bus.busy, exp_g[w]);
            end
            for (int h = 0; h < TB_HOLD; h++) begin
                @(negedge clk);
                total++;
                if (bus.q !== exp_d[w]) begin
                    bad++;
                    $display("[TB] FAIL rr_q[%0d]: got %h expected %h", w, bus.q, exp_d[w]);
                end
            end
            if (w == 4) bus.req = 4'b0000;
            @(negedge clk);
            total++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rr_idle[%0d]: got gnt=%b busy=%b expected gnt=0000 busy=0", w, bus.gnt, bus.busy);
            end
        end
    endtask

    // Single requester 2 writing A5: grant, q load, ack timing and nq
    task automatic test_single_write();
        set_lane(2, 8'hA5);
        sb.push_back('{ack: 4'b0100, data: 8'hA5});
        bus.req = 4'b0100;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL single_gnt: got %b expected 0100", bus.gnt); end
        total++;
        if (bus.q !== 8'h11) begin bad++; $display("[TB] FAIL single_q_grant: got %h expected 11", bus.q); end
        @(negedge clk);
        total++;
        if (bus.q !== 8'hA5 || bus.nq !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL single_q: got q=%h nq=%h expected q=a5 nq=5a", bus.q, bus.nq);
        end
        total++;
        if (bus.ack !== 4'b0000) begin bad++; $display("[TB] FAIL single_ack_early: got %b expected 0000", bus.ack); end
        @(negedge clk);
        total++;
        if (bus.ack !== 4'b0100) begin bad++; $display("[TB] FAIL single_ack: got %b expected 0100", bus.ack); end
        bus.req = 4'b0000;
        @(negedge clk);
        total++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL single_end: got ack=%b busy=%b gnt=%b expected 0000/0/0000", bus.ack, bus.busy, bus.gnt);
        end
    endtask

    // Owner drops req right after grant; write must still complete with ack
    task automatic test_early_drop();
        int n;
        set_lane(0, 8'h5E);
        sb.push_back('{ack: 4'b0001, data: 8'h5E});
        bus.req = 4'b0001;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL drop_gnt: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0000;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin bad++; $display("[TB] FAIL drop_timeout: busy still %b after %0d cycles, expected 0", bus.busy, n); end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL drop_ack_missing: got %0d pending writes expected 0", sb.size()); end
        total++;
        if (bus.q !== 8'h5E) begin bad++; $display("[TB] FAIL drop_q: got %h expected 5e", bus.q); end
    endtask

    // Lane changes during HOLD and IDLE must not reach q
    task automatic test_data_isolation();
        set_lane(3, 8'h3C);
        sb.push_back('{ack: 4'b1000, data: 8'h3C});
        bus.req = 4'b1000;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b1000) begin bad++; $display("[TB] FAIL iso_gnt: got %b expected 1000", bus.gnt); end
        @(negedge clk);
        total++;
        if (bus.q !== 8'h3C) begin bad++; $display("[TB] FAIL iso_q_load: got %h expected 3c", bus.q); end
        set_lane(3, 8'hC3);
        bus.req = 4'b0000;
        @(negedge clk);
        total++;
        if (bus.q !== 8'h3C) begin bad++; $display("[TB] FAIL iso_q_hold: got %h expected 3c", bus.q); end
        @(negedge clk);
        set_lane(3, 8'h99);
        @(negedge clk);
        total++;
        if (bus.q !== 8'h3C) begin bad++; $display("[TB] FAIL iso_q_idle: got %h expected 3c", bus.q); end
    endtask

    // Async reset in HOLD aborts the write; afterwards requester 1 wins first
    task automatic test_reset_mid_hold();
        int n;
        set_lane(2, 8'hFF);
        bus.req = 4'b0100;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL rmh_gnt: got %b expected 0100", bus.gnt); end
        @(negedge clk);
        total++;
        if (bus.q !== 8'hFF) begin bad++; $display("[TB] FAIL rmh_q_load: got %h expected ff", bus.q); end
        #2 reset = 1'b0;
        bus.req = 4'b0000;
        #1;
        total++;
        if (bus.q !== 8'h00 || bus.nq !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL rmh_async_q: got q=%h nq=%h expected q=00 nq=ff", bus.q, bus.nq);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.ack !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rmh_async_ctl: got busy=%b gnt=%b ack=%b expected 0/0000/0000", bus.busy, bus.gnt, bus.ack);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        set_lane(1, 8'h77);
        sb.push_back('{ack: 4'b0010, data: 8'h77});
        bus.req = 4'b0010;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL rmh_first_gnt: got %b expected 0010", bus.gnt); end
        bus.req = 4'b0000;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL rmh_complete: got cycles=%0d pending=%0d expected <20 and 0", n, sb.size());
        end
    endtask

    // Requesters 0 and 1 held high with ptr at 2: grants 0,1,0, so a re-requesting owner yields
    task automatic test_back_to_back();
        logic [3:0] exp_g [3];
        logic [7:0] exp_d [3];
        exp_g = '{4'b0001, 4'b0010, 4'b0001};
        exp_d = '{8'hA0, 8'hB1, 8'hA0};
        set_lane(0, 8'hA0); set_lane(1, 8'hB1);
        for (int w = 0; w < 3; w++) sb.push_back('{ack: exp_g[w], data: exp_d[w]});
        bus.req = 4'b0011;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            total++;
            if (bus.gnt !== exp_g[w]) begin
                bad++;
                $display("[TB] FAIL b2b_gnt[%0d]: got %b expected %b", w, bus.gnt, exp_g[w]);
            end
            for (int h = 0; h < TB_HOLD; h++) begin
                @(negedge clk);
                total++;
                if (bus.gnt !== exp_g[w]) begin
                    bad++;
                    $display("[TB] FAIL b2b_gnt_stable[%0d]: got %b expected %b", w, bus.gnt, exp_g[w]);
                end
            end
            if (w == 2) bus.req = 4'b0000;
            @(negedge clk);
            total++;
            if (bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL b2b_idle[%0d]: got busy=%b expected 0", w, bus.busy);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        bus.req   = 4'b0000;
        bus.wdata = '0;
        test_reset();
        test_round_robin();
        test_single_write();
        test_early_drop();
        test_data_isolation();
        test_reset_mid_hold();
        test_back_to_back();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_leftover: got %0d pending writes expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q8_reg_arbiter.md
Q8_REG_ARBITER -- requirements
Module: q8_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the shared register and of each write-data lane.
REQ-002 Parameter HOLD, default 2, SHALL set the number of cycles the register is held per grant; HOLD<1 SHALL be an elaboration error.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 req  input  4  SHALL be the per-requester write request, level; bit i = requester i.
REQ-006 wdata  input  4*WIDTH  SHALL carry the write data, lane i at bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  SHALL be the one-hot grant to the current owner; all-zero when idle.
REQ-008 ack  output  4  SHALL be the one-hot, one-cycle write-complete pulse to the owner.
REQ-009 q  output  WIDTH  SHALL be the shared register value.
REQ-010 nq  output  WIDTH  SHALL always equal ~q.
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and HOLD.
REQ-013 IDLE: if req != 0 at a rising edge, the FSM SHALL go to GRANT and register gnt = one-hot winner; otherwise it SHALL stay in IDLE.
REQ-014 Winner: first set req bit searching ptr, ptr+1, ... modulo 4; ptr is 2 bits.
REQ-015 GRANT lasts exactly one cycle; at its closing edge q SHALL load the winner's wdata lane, the FSM SHALL go to HOLD, and the hold counter SHALL load HOLD-1.
REQ-016 HOLD: the counter SHALL decrement each cycle; the cycle with counter==0 SHALL assert ack for the winner; at that cycle's closing edge the FSM SHALL go to IDLE, gnt SHALL clear and ptr SHALL become winner+1 mod 4.
REQ-017 gnt SHALL stay constant from GRANT entry through the last HOLD cycle.
REQ-018 q SHALL change only at the GRANT->HOLD edge or on reset; wdata changes at any other time SHALL have no effect.
REQ-019 Latency: with req sampled at edge E0, q SHALL update at E1, ack SHALL be high for cycle E(HOLD)..E(HOLD+1), and busy SHALL drop at E(HOLD+1).
REQ-020 Once granted, a write SHALL complete and ack SHALL fire even if the owner drops req before ack.
REQ-021 Each write SHALL be followed by at least one IDLE cycle, so back-to-back grants are separated by one cycle.
REQ-022 A requester holding req high after its ack SHALL be re-arbitrated normally and SHALL lose to any other asserted requester, because ptr has advanced.
REQ-023 req changes during GRANT or HOLD SHALL NOT alter the current owner.
REQ-024 At most one bit of gnt and at most one bit of ack SHALL be set in any cycle.

Reset
REQ-025 reset low SHALL immediately, without waiting for clk, force: state IDLE, q=0, nq=all ones, gnt=0, ack=0, busy=0, ptr=0, counter=0.
REQ-026 reset asserted mid-GRANT or mid-HOLD SHALL abort the write with no ack; q SHALL go to 0.
REQ-027 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset high.

Verification
REQ-028 Reset: hold reset low 100 ns with clk toggling, then release -> q=8'h00, nq=8'hFF, gnt=0, busy=0 throughout.
REQ-029 Single write: req=4'b0100, lane2=8'hA5 -> gnt=4'b0100 one cycle later; q=8'hA5 next edge; ack=4'b0100 for one cycle after 2 HOLD cycles; nq=8'h5A.
REQ-030 Round-robin: req=4'b1111 held, lanes=8'h11/8'h22/8'h33/8'h44 -> grants in order 0,1,2,3,0 with one IDLE cycle between writes; q sequence 11,22,33,44,11.
REQ-031 Early drop: req=4'b0001, dropped the cycle after gnt -> write of lane0 still completes and ack=4'b0001 fires.
REQ-032 Reset mid-HOLD: reset low during HOLD of a write of 8'hFF -> q=0 asynchronously, no ack pulse, busy=0; after release, req=4'b0010 is granted first.
REQ-033 Data isolation: change lane value during HOLD -> q unchanged until the next GRANT->HOLD edge.
